// File: rtl/attn_sched_pkg.sv
// Shared types and constants for the attention-engine scheduler.
// The state enum is exported so debug probes can decode the arbiter FSM.
package attn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    BUSY  = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } sched_state_t;

  localparam int JOB_CNT_W = 16;

  // (base + off) mod n, for round-robin search with wrap
  function automatic int wrap_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
// rr_ptr is always kept below NUM_REQ by the owner of this block.
module rr_arbiter
  import attn_sched_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]  pick_onehot,
  output logic [ID_WIDTH-1:0] pick_idx,
  output logic                valid
);

  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    pick_onehot = '0;
    pick_idx    = '0;
    valid       = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_WIDTH'(wrap_index(32'(rr_ptr), i, NUM_REQ));
      if (!valid && req[idx]) begin
        valid            = 1'b1;
        pick_idx         = idx;
        pick_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/attn_engine_arbiter.sv
// Round-robin owner of a single attention engine: clear, start, watch, then ack/err.
// Every output is a register loaded from the next-state logic below.
module attn_engine_arbiter
  import attn_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1),
  parameter int ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   err,
  output logic [ID_WIDTH-1:0]  owner_id,
  output logic                 busy,
  output logic                 engine_rst,
  output logic                 engine_start,
  input  logic                 engine_done,
  output logic [JOB_CNT_W-1:0] job_count
);

  sched_state_t         state_q, state_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TO_WIDTH-1:0]  wd_q, wd_d;
  logic [NUM_REQ-1:0]   grant_d, ack_d, err_d;
  logic [ID_WIDTH-1:0]  owner_d;
  logic                 busy_d, engine_rst_d, engine_start_d;
  logic [JOB_CNT_W-1:0] job_count_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 pick_valid;
  logic [ID_WIDTH-1:0]  rr_after_owner;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_rr (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .pick_onehot(pick_onehot),
    .pick_idx   (pick_idx),
    .valid      (pick_valid)
  );

  assign rr_after_owner = (owner_id == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                               : owner_id + ID_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      wd_q         <= '0;
      grant        <= '0;
      ack          <= '0;
      err          <= '0;
      owner_id     <= '0;
      busy         <= 1'b0;
      engine_rst   <= 1'b0;
      engine_start <= 1'b0;
      job_count    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      wd_q         <= wd_d;
      grant        <= grant_d;
      ack          <= ack_d;
      err          <= err_d;
      owner_id     <= owner_d;
      busy         <= busy_d;
      engine_rst   <= engine_rst_d;
      engine_start <= engine_start_d;
      job_count    <= job_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    wd_d           = wd_q;
    grant_d        = grant;
    owner_d        = owner_id;
    busy_d         = busy;
    job_count_d    = job_count;
    ack_d          = '0;
    err_d          = '0;
    engine_rst_d   = 1'b0;
    engine_start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = CLEAR;
          grant_d      = pick_onehot;
          owner_d      = pick_idx;
          busy_d       = 1'b1;
          engine_rst_d = 1'b1;
        end
      end
      CLEAR: begin
        state_d        = START;
        engine_start_d = 1'b1;
        wd_d           = '0;
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        // engine_done is only trusted here, after the engine was cleared for this job
        if (engine_done) begin
          state_d     = DONE;
          ack_d       = grant;
          job_count_d = job_count + JOB_CNT_W'(1);
          rr_ptr_d    = rr_after_owner;
        end else if (wd_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          state_d      = ABORT;
          err_d        = grant;
          engine_rst_d = 1'b1;
          rr_ptr_d     = rr_after_owner;
        end else begin
          wd_d = wd_q + TO_WIDTH'(1);
        end
      end
      DONE, ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
